// File: rtl/kmap_pkg.sv
// rtl/kmap_pkg.sv - shared types and sizes for the 4-input truth table scanner
package kmap_pkg;

    localparam int NUM_VARS     = 4;
    localparam int NUM_MINTERMS = 16;
    localparam int MINTERM_W    = 4;
    localparam int COUNT_W      = 5;

    localparam logic [MINTERM_W-1:0] LAST_MINTERM = MINTERM_W'(NUM_MINTERMS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/kmap_truth_table_scanner_if.sv
// rtl/kmap_truth_table_scanner_if.sv - control, function-under-test and result signals of the scanner
interface kmap_truth_table_scanner_if;
    import kmap_pkg::*;

    logic                     start;
    logic [NUM_MINTERMS-1:0]  expected;
    logic                     f_in;
    logic [MINTERM_W-1:0]     pqrs_out;
    logic                     busy;
    logic                     done;
    logic [NUM_MINTERMS-1:0]  truth_table;
    logic [NUM_MINTERMS-1:0]  mismatch_mask;
    logic [COUNT_W-1:0]       mismatch_count;
    logic                     pass;

    modport master (
        output start, expected, f_in,
        input  pqrs_out, busy, done, truth_table, mismatch_mask, mismatch_count, pass
    );

    modport slave (
        input  start, expected, f_in,
        output pqrs_out, busy, done, truth_table, mismatch_mask, mismatch_count, pass
    );

endinterface

// File: rtl/kmap_settle_timer.sv
// rtl/kmap_settle_timer.sv - loadable down-counter that flags expiry at zero
module kmap_settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/kmap_truth_table_scanner.sv
// rtl/kmap_truth_table_scanner.sv - sweeps {P,Q,R,S}, captures F and scores it against an expected table
module kmap_truth_table_scanner
    import kmap_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    kmap_truth_table_scanner_if.slave bus
);

    localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] SETTLE = ST_SETTLE;
    localparam logic [1:0] SAMPLE = ST_SAMPLE;
    localparam logic [1:0] DONE   = ST_DONE;

    logic [1:0]              state;
    logic [MINTERM_W-1:0]    index;
    logic [NUM_MINTERMS-1:0] snap;
    logic [NUM_MINTERMS-1:0] truth_table_q;
    logic [NUM_MINTERMS-1:0] mask_q;
    logic [COUNT_W-1:0]      count_q;
    logic                    pass_q;
    logic                    done_q;

    logic timer_load;
    logic timer_expired;
    logic accept;
    logic miss_bit;

    assign accept   = (state == IDLE) && bus.start;
    assign miss_bit = bus.f_in ^ snap[index];

    // Timer is reloaded for every minterm, so each one gets the full settle window.
    assign timer_load = accept || (state == SAMPLE && index != LAST_MINTERM);

    kmap_settle_timer #(
        .W (TW)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (TW'(SETTLE_CYCLES - 1)),
        .en       (state == SETTLE),
        .expired  (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            index         <= '0;
            snap          <= '0;
            truth_table_q <= '0;
            mask_q        <= '0;
            count_q       <= '0;
            pass_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        snap          <= bus.expected;
                        index         <= '0;
                        truth_table_q <= '0;
                        mask_q        <= '0;
                        count_q       <= '0;
                        pass_q        <= 1'b0;
                        state         <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (timer_expired) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    truth_table_q[index] <= bus.f_in;
                    mask_q[index]        <= miss_bit;
                    count_q              <= count_q + {{(COUNT_W-1){1'b0}}, miss_bit};
                    if (index == LAST_MINTERM) begin
                        state <= DONE;
                    end else begin
                        index <= index + 1'b1;
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    // Count is final here, so the verdict and pulse land together.
                    done_q <= 1'b1;
                    pass_q <= (count_q == '0);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pqrs_out       = index;
    assign bus.busy           = (state == SETTLE) || (state == SAMPLE);
    assign bus.done           = done_q;
    assign bus.truth_table    = truth_table_q;
    assign bus.mismatch_mask  = mask_q;
    assign bus.mismatch_count = count_q;
    assign bus.pass           = pass_q;

endmodule

// File: tb/tb_kmap_truth_table_scanner.sv
// tb/tb_kmap_truth_table_scanner.sv - randomized self-checking bench for the truth table scanner
module tb_kmap_truth_table_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kmap_truth_table_scanner_if a_if ();
    kmap_truth_table_scanner_if b_if ();

    logic [15:0] func_a = 16'h0;
    logic [15:0] func_b = 16'h0;
    logic        f_b_q  = 1'b0;

    assign a_if.f_in = func_a[a_if.pqrs_out];
    always @(posedge clk) f_b_q <= func_b[b_if.pqrs_out];
    assign b_if.f_in = f_b_q;

    kmap_truth_table_scanner #(.SETTLE_CYCLES(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    kmap_truth_table_scanner #(.SETTLE_CYCLES(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sop_table();
        logic [15:0] t;
        logic p, q, r, s;
        for (int i = 0; i < 16; i++) begin
            p = i[3]; q = i[2]; r = i[1]; s = i[0];
            t[i] = (q & s) | (!p & !r & s) | (p & q & r) | (!p & r & s) | (p & !q & !r);
        end
        return t;
    endfunction

    task automatic check_zero_a(input string tag);
        check({tag, "_pqrs"}, 32'(a_if.pqrs_out), 0);
        check({tag, "_busy"}, 32'(a_if.busy), 0);
        check({tag, "_done"}, 32'(a_if.done), 0);
        check({tag, "_tt"},   32'(a_if.truth_table), 0);
        check({tag, "_mask"}, 32'(a_if.mismatch_mask), 0);
        check({tag, "_cnt"},  32'(a_if.mismatch_count), 0);
        check({tag, "_pass"}, 32'(a_if.pass), 0);
    endtask

    // Starts a scan on dut_a; optionally re-pulses start and flips expected mid-scan.
    task automatic scan_a(input logic [15:0] exp, input int pulse_at, input int chg_at, output int lat);
        @(negedge clk);
        a_if.expected = exp;
        a_if.start    = 1'b1;
        @(posedge clk);
        #1 a_if.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (a_if.done) begin
                lat = n;
                break;
            end
            a_if.start = (n == pulse_at);
            if (n == chg_at) a_if.expected = ~exp;
        end
        a_if.start = 1'b0;
    endtask

    task automatic verify_a(input string tag, input logic [15:0] func, input logic [15:0] exp,
                            input int lat, input int want_lat);
        logic [15:0] diff;
        diff = func ^ exp;
        check({tag, "_lat"},  32'(lat), 32'(want_lat));
        check({tag, "_tt"},   32'(a_if.truth_table), 32'(func));
        check({tag, "_mask"}, 32'(a_if.mismatch_mask), 32'(diff));
        check({tag, "_cnt"},  32'(a_if.mismatch_count), 32'($countones(diff)));
        check({tag, "_pass"}, 32'(a_if.pass), 32'(diff == 16'h0));
        check({tag, "_busy"}, 32'(a_if.busy), 0);
        check({tag, "_pqrs"}, 32'(a_if.pqrs_out), 15);
        @(posedge clk);
        #1 check({tag, "_pulse"}, 32'(a_if.done), 0);
    endtask

    initial begin
        int lat;
        int first_done;
        int second_done;
        int dones;
        logic [15:0] exp;
        logic [15:0] diff;

        a_if.start = 1'b0; a_if.expected = 16'h0;
        b_if.start = 1'b0; b_if.expected = 16'h0;

        repeat (3) @(posedge clk);
        #1 check_zero_a("reset");
        check("reset_b_pqrs", 32'(b_if.pqrs_out), 0);
        check("reset_b_pass", 32'(b_if.pass), 0);
        @(negedge clk) rst_n = 1'b1;

        func_a = sop_table();
        check("sop_model", 32'(func_a), 32'h0000E3AA);
        scan_a(16'hE3AA, -1, -1, lat);
        verify_a("t1", func_a, 16'hE3AA, lat, 49);

        scan_a(16'hE3AB, -1, -1, lat);
        verify_a("t2", func_a, 16'hE3AB, lat, 49);

        func_a = 16'h0;
        scan_a(16'hFFFF, -1, -1, lat);
        verify_a("t3", func_a, 16'hFFFF, lat, 49);
        check("t3_cnt16", 32'(a_if.mismatch_count), 16);

        func_a = 16'(($urandom));
        exp    = 16'(($urandom));
        scan_a(exp, 10, 5, lat);
        verify_a("t4", func_a, exp, lat, 49);

        for (int it = 0; it < 6; it++) begin
            func_a = 16'(($urandom));
            case ($urandom_range(0, 2))
                0:       exp = func_a;
                1:       exp = func_a ^ (16'h1 << $urandom_range(0, 15));
                default: exp = 16'(($urandom));
            endcase
            scan_a(exp, -1, -1, lat);
            verify_a($sformatf("rnd%0d", it), func_a, exp, lat, 49);
        end

        // Start held high: back-to-back scans separated by one IDLE cycle.
        func_a = 16'(($urandom));
        exp    = 16'(($urandom));
        first_done = -1;
        second_done = -1;
        @(negedge clk);
        a_if.expected = exp;
        a_if.start    = 1'b1;
        for (int n = 0; n <= 150; n++) begin
            @(posedge clk);
            #1;
            if (a_if.done) begin
                if (first_done < 0) first_done = n;
                else begin
                    second_done = n;
                    a_if.start = 1'b0;
                    break;
                end
            end
        end
        a_if.start = 1'b0;
        check("b2b_first", 32'(first_done), 49);
        check("b2b_gap", 32'(second_done - first_done), 50);
        diff = func_a ^ exp;
        check("b2b_mask", 32'(a_if.mismatch_mask), 32'(diff));
        repeat (3) @(posedge clk);
        #1 check("b2b_idle", 32'(a_if.busy), 0);

        // Reset at cycle 20 of a scan aborts it with no done.
        func_a = 16'hFFFF;
        @(negedge clk);
        a_if.expected = 16'h0;
        a_if.start    = 1'b1;
        @(posedge clk);
        #1 a_if.start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #2 check_zero_a("abort");
        @(negedge clk) rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1 if (a_if.done) dones++;
        end
        check("abort_nodone", 32'(dones), 0);
        func_a = 16'(($urandom));
        exp    = 16'(($urandom));
        scan_a(exp, -1, -1, lat);
        verify_a("post_rst", func_a, exp, lat, 49);

        // Minimum settle with a registered function block.
        for (int it = 0; it < 3; it++) begin
            func_b = 16'(($urandom));
            exp    = (it == 0) ? func_b : 16'(($urandom));
            @(negedge clk);
            b_if.expected = exp;
            b_if.start    = 1'b1;
            @(posedge clk);
            #1 b_if.start = 1'b0;
            lat = -1;
            for (int n = 1; n <= 100; n++) begin
                @(posedge clk);
                #1;
                if (b_if.done) begin
                    lat = n;
                    break;
                end
            end
            diff = func_b ^ exp;
            check($sformatf("s1_%0d_lat", it), 32'(lat), 33);
            check($sformatf("s1_%0d_tt", it), 32'(b_if.truth_table), 32'(func_b));
            check($sformatf("s1_%0d_cnt", it), 32'(b_if.mismatch_count), 32'($countones(diff)));
            check($sformatf("s1_%0d_pass", it), 32'(b_if.pass), 32'(diff == 16'h0));
            repeat (2) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
